// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 4-digit seven-segment scanner.
package seg_pkg;
  localparam int          DIGITS  = 4;
  localparam int          IDX_W   = 2;
  localparam logic [3:0]  SEL_OFF = 4'b1111;
endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed 4-digit display scanner with dead-time blanking,
// frame-synchronous input shadowing and optional leading-zero suppression.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] disp_data,
  input  logic [3:0]  disp_dp,
  input  logic        disp_en,
  input  logic        lz_en,
  output logic [3:0]  seg_data,
  output logic [3:0]  seg_sel,
  output logic        seg_dp,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic             shadow_lz_q, shadow_lz_d;
  logic [3:0]       seg_data_q, seg_data_d;
  logic [3:0]       seg_sel_q, seg_sel_d;
  logic             seg_dp_q, seg_dp_d;
  logic             frame_done_q, frame_done_d;

  logic             wrap_slot;
  logic             frame_load;
  logic             lit;
  logic [3:0]       blank_vec;

  always_comb begin
    wrap_slot   = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_load  = wrap_slot && (idx_q == IDX_W'(DIGITS - 1));
    slot_cnt_d  = wrap_slot ? '0 : slot_cnt_q + CNT_W'(1);
    idx_d       = wrap_slot ? idx_q + IDX_W'(1) : idx_q;

    shadow_d    = frame_load ? disp_data : shadow_q;
    shadow_dp_d = frame_load ? disp_dp   : shadow_dp_q;
    shadow_lz_d = frame_load ? lz_en     : shadow_lz_q;

    // A digit is blankable only if it and every digit above it are zero
    // with no decimal point requested; digit 0 always stays lit.
    blank_vec    = 4'b0000;
    blank_vec[3] = shadow_lz_d && (shadow_d[15:12] == 4'h0) && !shadow_dp_d[3];
    for (int i = DIGITS - 2; i >= 1; i--) begin
      blank_vec[i] = blank_vec[i+1] && (shadow_d[4*i +: 4] == 4'h0) && !shadow_dp_d[i];
    end

    lit = disp_en && (slot_cnt_d >= CNT_W'(DEAD_CYC)) && !blank_vec[idx_d];

    seg_data_d   = shadow_d[{idx_d, 2'b00} +: 4];
    seg_sel_d    = lit ? ~(4'b0001 << idx_d) : SEL_OFF;
    seg_dp_d     = lit ? ~shadow_dp_d[idx_d] : 1'b1;
    frame_done_d = frame_load;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      shadow_lz_q  <= 1'b0;
      seg_data_q   <= 4'h0;
      seg_sel_q    <= SEL_OFF;
      seg_dp_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_lz_q  <= shadow_lz_d;
      seg_data_q   <= seg_data_d;
      seg_sel_q    <= seg_sel_d;
      seg_dp_q     <= seg_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_data   = seg_data_q;
  assign seg_sel    = seg_sel_q;
  assign seg_dp     = seg_dp_q;
  assign frame_done = frame_done_q;

endmodule
